// File: rtl/ascii_encode_tx.sv
// Encodes char / hex byte / line end / ESC clear requests into ASCII bytes for the UART TX.
// Optional macro ENCODE_FILTER_EN replaces non-printable chars with '.' and adds filt_hit.
module ascii_encode_tx #(
    parameter bit HEX_UPPER = 1'b0,
    parameter bit CR_ONLY   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_type,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic [7:0] txData,
    output logic       txDataValid,
    input  logic       txReady,
`ifdef ENCODE_FILTER_EN
    output logic       filt_hit,
`endif
    output logic       busy
);

    // Handshakes: a request transfers on an edge where req_valid & req_ready,
    // a byte transfers on an edge where txDataValid & txReady; valid holds until then.
    typedef enum logic {IDLE, EMIT} state_t;

    state_t     state;
    logic [1:0] lat_type;
    logic [7:0] lat_data;
    logic [1:0] idx;
    logic [1:0] last;
    logic [7:0] acc_data;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return {4'h3, n};
        return (HEX_UPPER ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    endfunction

    function automatic logic [7:0] seq_byte(input logic [1:0] t, input logic [7:0] d,
                                            input logic [1:0] i);
        logic [7:0] b;
        b = 8'h00;
        case (t)
            2'b00: b = d;
            2'b01: b = (i == 2'd0) ? hex_ascii(d[7:4]) : hex_ascii(d[3:0]);
            2'b10: b = (i == 2'd0) ? 8'h0D : 8'h0A;
            default: begin
                case (i)
                    2'd0:    b = 8'h1B;
                    2'd1:    b = 8'h5B;
                    2'd2:    b = 8'h32;
                    default: b = 8'h4A;
                endcase
            end
        endcase
        return b;
    endfunction

    function automatic logic [1:0] seq_last(input logic [1:0] t);
        logic [1:0] l;
        case (t)
            2'b00:   l = 2'd0;
            2'b01:   l = 2'd1;
            2'b10:   l = CR_ONLY ? 2'd0 : 2'd1;
            default: l = 2'd3;
        endcase
        return l;
    endfunction

`ifdef ENCODE_FILTER_EN
    logic replace;
    // Printable range plus CR and ESC pass; anything else becomes '.'.
    assign replace  = (req_type == 2'b00) &&
                      (req_data < 8'h20 || req_data > 8'h7E) &&
                      (req_data != 8'h0D) && (req_data != 8'h1B);
    assign acc_data = replace ? 8'h2E : req_data;
`else
    assign acc_data = req_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            busy        <= 1'b0;
            txDataValid <= 1'b0;
            txData      <= 8'h00;
            idx         <= 2'd0;
            last        <= 2'd0;
            lat_type    <= 2'b00;
            lat_data    <= 8'h00;
`ifdef ENCODE_FILTER_EN
            filt_hit    <= 1'b0;
`endif
        end else begin
`ifdef ENCODE_FILTER_EN
            filt_hit <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_type    <= req_type;
                        lat_data    <= acc_data;
                        idx         <= 2'd0;
                        last        <= seq_last(req_type);
                        txData      <= seq_byte(req_type, acc_data, 2'd0);
                        txDataValid <= 1'b1;
                        busy        <= 1'b1;
                        req_ready   <= 1'b0;
                        state       <= EMIT;
`ifdef ENCODE_FILTER_EN
                        filt_hit    <= replace;
`endif
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    if (txReady) begin
                        if (idx == last) begin
                            state       <= IDLE;
                            txDataValid <= 1'b0;
                            busy        <= 1'b0;
                            req_ready   <= 1'b1;
                            idx         <= 2'd0;
                        end else begin
                            idx    <= idx + 2'd1;
                            txData <= seq_byte(lat_type, lat_data, idx + 2'd1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_encode_tx.sv
// Bench for ascii_encode_tx: queue-based byte model checked every cycle, directed scenarios, random traffic.
module tb_ascii_encode_tx;

    localparam bit HEX_UPPER = 1'b0;
    localparam bit CR_ONLY   = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_type = 2'b00;
    logic [7:0] req_data = 8'h00;
    logic       txReady = 1'b0;
    logic       req_ready;
    logic [7:0] txData;
    logic       txDataValid;
    logic       busy;
`ifdef ENCODE_FILTER_EN
    logic       filt_hit;
`endif

    ascii_encode_tx #(.HEX_UPPER(HEX_UPPER), .CR_ONLY(CR_ONLY)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_type    (req_type),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .txData      (txData),
        .txDataValid (txDataValid),
        .txReady     (txReady),
`ifdef ENCODE_FILTER_EN
        .filt_hit    (filt_hit),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every accepted request appends its whole byte string to exp_q;
    // the front of exp_q is what must be on txData.
    logic [7:0] exp_q[$];
    logic [7:0] xfer_log[$];
    logic       m_ready = 1'b0;
    logic       m_zero  = 1'b1;
    logic       m_filt  = 1'b0;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        string digits;
        digits = HEX_UPPER ? "0123456789ABCDEF" : "0123456789abcdef";
        return digits.getc(int'(n));
    endfunction

    task automatic push_seq(input logic [1:0] t, input logic [7:0] d);
        logic [7:0] c;
        c = d;
        case (t)
            2'b00: begin
`ifdef ENCODE_FILTER_EN
                if ((d < 8'd32 || d > 8'd126) && d != 8'd13 && d != 8'd27) begin
                    c = 8'h2E;
                    m_filt = 1'b1;
                end
`endif
                exp_q.push_back(c);
            end
            2'b01: begin
                exp_q.push_back(hex_char(d[7:4]));
                exp_q.push_back(hex_char(d[3:0]));
            end
            2'b10: begin
                exp_q.push_back(8'h0D);
                if (!CR_ONLY) exp_q.push_back(8'h0A);
            end
            default: begin
                exp_q.push_back(8'h1B);
                exp_q.push_back(8'h5B);
                exp_q.push_back(8'h32);
                exp_q.push_back(8'h4A);
            end
        endcase
    endtask

    always @(posedge clk) begin
        if (txDataValid && txReady && !rst) xfer_log.push_back(txData);
        m_filt = 1'b0;
        if (rst) begin
            exp_q.delete();
            m_ready = 1'b0;
            m_zero  = 1'b1;
        end else if (exp_q.size() > 0) begin
            if (txReady) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) m_ready = 1'b1;
            end
        end else if (m_ready && req_valid) begin
            push_seq(req_type, req_data);
            m_ready = 1'b0;
            m_zero  = 1'b0;
        end else begin
            m_ready = 1'b1;
        end
    end

    always @(posedge clk) begin
        #1;
        check("req_ready", req_ready, m_ready);
        check("busy", busy, exp_q.size() > 0);
        check("txDataValid", txDataValid, exp_q.size() > 0);
        if (exp_q.size() > 0)
            check("txData", txData, exp_q[0]);
        else if (m_zero)
            check("txData_reset", txData, 8'h00);
`ifdef ENCODE_FILTER_EN
        check("filt_hit", filt_hit, m_filt);
`endif
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [1:0] t, input logic [7:0] d);
        req_valid = 1'b1;
        req_type  = t;
        req_data  = d;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64; i++) begin
            if (!busy && req_ready) return;
            step();
        end
        check("wait_idle_timeout", busy, 1'b0);
    endtask

    task automatic check_log(input string name, input logic [7:0] exp_bytes[$]);
        check({name, "_count"}, xfer_log.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < xfer_log.size(); i++)
            check({name, "_byte"}, xfer_log[i], exp_bytes[i]);
    endtask

    initial begin
        // reset values
        step();
        step();
        check("rst_valid", txDataValid, 1'b0);
        check("rst_data", txData, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", req_ready, 1'b0);
        rst = 1'b0;
        step();
        check("post_rst_ready", req_ready, 1'b1);

        // hex 0x3F -> "3f"
        txReady = 1'b1;
        send(2'b01, 8'h3F);
        step();
        req_valid = 1'b0;
        check("hex_b0", txData, 8'h33);
        check("hex_b0_busy", busy, 1'b1);
        step();
        check("hex_b1", txData, 8'h66);
        check("hex_b1_busy", busy, 1'b1);
        step();
        check("hex_done_busy", busy, 1'b0);
        check("hex_done_ready", req_ready, 1'b1);

        // line end under 5 cycles of backpressure
        txReady = 1'b0;
        send(2'b10, 8'($urandom));
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("bp_cr", txData, 8'h0D);
            check("bp_cr_valid", txDataValid, 1'b1);
            if (i == 5) txReady = 1'b1;
            step();
        end
        check("bp_lf", txData, 8'h0A);
        step();
        check("bp_end_valid", txDataValid, 1'b0);

        // ESC clear with toggling txReady
        wait_idle();
        xfer_log.delete();
        send(2'b11, 8'h00);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            txReady = (i % 2 == 0);
            step();
        end
        txReady = 1'b1;
        wait_idle();
        check_log("esc_toggle", '{8'h1B, 8'h5B, 8'h32, 8'h4A});

        // request held during ESC sequence
        xfer_log.delete();
        send(2'b11, 8'h00);
        step();
        send(2'b00, 8'h41);
        step();
        step();
        step();
        step();
        check("busy_req_gap_valid", txDataValid, 1'b0);
        check("busy_req_gap_ready", req_ready, 1'b1);
        step();
        check("busy_req_char", txData, 8'h41);
        req_valid = 1'b0;
        step();
        step();
        check_log("busy_req", '{8'h1B, 8'h5B, 8'h32, 8'h4A, 8'h41});

        // reset pulse during byte 2 of ESC
        wait_idle();
        xfer_log.delete();
        send(2'b11, 8'h00);
        step();
        req_valid = 1'b0;
        step();
        check("rstmid_b1", txData, 8'h5B);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid_valid", txDataValid, 1'b0);
        check("rstmid_data", txData, 8'h00);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_ready0", req_ready, 1'b0);
        step();
        check("rstmid_ready1", req_ready, 1'b1);
        for (int i = 0; i < 5; i++) step();
        check_log("rstmid", '{8'h1B});

`ifdef ENCODE_FILTER_EN
        send(2'b00, 8'h07);
        step();
        req_valid = 1'b0;
        check("filt_dot", txData, 8'h2E);
        check("filt_hit_on", filt_hit, 1'b1);
        step();
        check("filt_hit_off", filt_hit, 1'b0);
        wait_idle();
        send(2'b00, 8'h0D);
        step();
        req_valid = 1'b0;
        check("filt_cr", txData, 8'h0D);
        check("filt_cr_hit", filt_hit, 1'b0);
        wait_idle();
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            req_valid = ($urandom_range(0, 2) != 0);
            req_type  = 2'($urandom_range(0, 3));
            req_data  = 8'($urandom);
            txReady   = ($urandom_range(0, 3) != 0);
            step();
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        txReady   = 1'b1;
        step();
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
